audio_cfg_ctl: RTL

Configuration sequencer for the audio output path. It holds HPS-written shadow copies of the IIR filter coefficients, filter rate, attenuation and mix mode, and commits them to the live audio path only at a safe point. Each commit fades attenuation out to mute, swaps all settings atomically, pulses a filter-state clear, waits a settle interval, then fades back in. It sits between the HPS config register bus and the audio output block's flt_rate/cx*/cy*/att/mix inputs.

---
 rtl/audio_cfg_ctl.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/audio_cfg_ctl.sv
// Audio output config sequencer: HPS-written shadow registers are committed to the live
// filter/mix outputs via fade-out, atomic swap + filter clear, settle, and fade-in.
module audio_cfg_ctl #(
  parameter int unsigned SETTLE_SAMPLES = 16
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        sample_ce_i,
  input  logic        wr_i,
  input  logic [3:0]  addr_i,
  input  logic [15:0] din_i,
  output logic [31:0] flt_rate_o,
  output logic [39:0] cx_o,
  output logic [7:0]  cx0_o,
  output logic [7:0]  cx1_o,
  output logic [7:0]  cx2_o,
  output logic [23:0] cy0_o,
  output logic [23:0] cy1_o,
  output logic [23:0] cy2_o,
  output logic [4:0]  att_o,
  output logic [1:0]  mix_o,
  output logic        flt_clr_o,
  output logic        busy_o
);

  localparam logic [4:0] ATT_MUTE = 5'd16;
  localparam logic [7:0] SETTLE_N = SETTLE_SAMPLES[7:0];

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FADE_OUT = 3'd1,
    S_SWAP     = 3'd2,
    S_SETTLE   = 3'd3,
    S_FADE_IN  = 3'd4
  } state_e;

  state_e state_q, state_d;

  // Shadow copies, written directly by the config bus.
  logic [31:0] sh_flt_rate_q;
  logic [39:0] sh_cx_q;
  logic [7:0]  sh_cx0_q, sh_cx1_q, sh_cx2_q;
  logic [23:0] sh_cy0_q, sh_cy1_q, sh_cy2_q;
  logic [4:0]  sh_att_q;
  logic [1:0]  sh_mix_q;

  logic [31:0] lv_flt_rate_q;
  logic [39:0] lv_cx_q;
  logic [7:0]  lv_cx0_q, lv_cx1_q, lv_cx2_q;
  logic [23:0] lv_cy0_q, lv_cy1_q, lv_cy2_q;
  logic [4:0]  lv_att_q;
  logic [1:0]  lv_mix_q;

  logic [4:0]  cur_att_q, cur_att_d;
  logic [7:0]  settle_cnt_q, settle_cnt_d;
  logic        pending_q, pending_d;
  logic        flt_clr_q, flt_clr_d;
  logic        busy_q, busy_d;
  logic        swap_en;
  logic        commit_wr;

  assign commit_wr = wr_i && (addr_i == 4'd15);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      sh_flt_rate_q <= '0;
      sh_cx_q       <= '0;
      sh_cx0_q      <= '0;
      sh_cx1_q      <= '0;
      sh_cx2_q      <= '0;
      sh_cy0_q      <= '0;
      sh_cy1_q      <= '0;
      sh_cy2_q      <= '0;
      sh_att_q      <= ATT_MUTE;
      sh_mix_q      <= '0;
    end else if (wr_i) begin
      case (addr_i)
        4'd0:  sh_flt_rate_q[15:0]  <= din_i;
        4'd1:  sh_flt_rate_q[31:16] <= din_i;
        4'd2:  sh_cx_q[15:0]        <= din_i;
        4'd3:  sh_cx_q[31:16]       <= din_i;
        4'd4:  sh_cx_q[39:32]       <= din_i[7:0];
        4'd5: begin
          sh_cx1_q <= din_i[15:8];
          sh_cx0_q <= din_i[7:0];
        end
        4'd6:  sh_cx2_q             <= din_i[7:0];
        4'd7:  sh_cy0_q[15:0]       <= din_i;
        4'd8:  sh_cy0_q[23:16]      <= din_i[7:0];
        4'd9:  sh_cy1_q[15:0]       <= din_i;
        4'd10: sh_cy1_q[23:16]      <= din_i[7:0];
        4'd11: sh_cy2_q[15:0]       <= din_i;
        4'd12: sh_cy2_q[23:16]      <= din_i[7:0];
        4'd13: begin
          sh_att_q <= din_i[4:0];
          sh_mix_q <= din_i[6:5];
        end
        default: ;
      endcase
    end
  end

  // The swap samples pre-edge shadow values, so a same-cycle shadow write lands after it.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      lv_flt_rate_q <= '0;
      lv_cx_q       <= '0;
      lv_cx0_q      <= '0;
      lv_cx1_q      <= '0;
      lv_cx2_q      <= '0;
      lv_cy0_q      <= '0;
      lv_cy1_q      <= '0;
      lv_cy2_q      <= '0;
      lv_att_q      <= ATT_MUTE;
      lv_mix_q      <= '0;
    end else if (swap_en) begin
      lv_flt_rate_q <= sh_flt_rate_q;
      lv_cx_q       <= sh_cx_q;
      lv_cx0_q      <= sh_cx0_q;
      lv_cx1_q      <= sh_cx1_q;
      lv_cx2_q      <= sh_cx2_q;
      lv_cy0_q      <= sh_cy0_q;
      lv_cy1_q      <= sh_cy1_q;
      lv_cy2_q      <= sh_cy2_q;
      lv_att_q      <= sh_att_q;
      lv_mix_q      <= sh_mix_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      cur_att_q    <= ATT_MUTE;
      settle_cnt_q <= '0;
      pending_q    <= 1'b0;
      flt_clr_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_att_q    <= cur_att_d;
      settle_cnt_q <= settle_cnt_d;
      pending_q    <= pending_d;
      flt_clr_q    <= flt_clr_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          state_d = cur_att_q[4] ? S_SWAP : S_FADE_OUT;
        end
      end
      S_FADE_OUT: begin
        if (cur_att_q[4]) begin
          state_d = S_SWAP;
        end
      end
      S_SWAP: state_d = S_SETTLE;
      S_SETTLE: begin
        if (settle_cnt_q == SETTLE_N) begin
          state_d = S_FADE_IN;
        end
      end
      S_FADE_IN: begin
        if (pending_q) begin
          state_d = S_FADE_OUT;
        end else if (lv_att_q[4] || (cur_att_q == lv_att_q)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Fade steps only on sample_ce; cur_att is clamped to [target, 16].
  always_comb begin
    cur_att_d    = cur_att_q;
    settle_cnt_d = settle_cnt_q;
    swap_en      = 1'b0;
    unique case (state_q)
      S_IDLE: cur_att_d = lv_att_q;
      S_FADE_OUT: begin
        if (sample_ce_i && !cur_att_q[4]) begin
          cur_att_d = cur_att_q + 5'd1;
        end
      end
      S_SWAP: begin
        swap_en      = 1'b1;
        settle_cnt_d = '0;
      end
      S_SETTLE: begin
        cur_att_d = ATT_MUTE;
        if (sample_ce_i && (settle_cnt_q != SETTLE_N)) begin
          settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end
      S_FADE_IN: begin
        if (sample_ce_i && !pending_q && !lv_att_q[4] && (cur_att_q > lv_att_q)) begin
          cur_att_d = cur_att_q - 5'd1;
        end
      end
      default: ;
    endcase
  end

  // A commit landing in the swap cycle wins over the clear, forcing another full cycle.
  always_comb begin
    pending_d = pending_q;
    if (commit_wr) begin
      pending_d = 1'b1;
    end else if (swap_en) begin
      pending_d = 1'b0;
    end
    flt_clr_d = swap_en;
    busy_d    = pending_d || (state_d != S_IDLE);
  end

  assign flt_rate_o = lv_flt_rate_q;
  assign cx_o       = lv_cx_q;
  assign cx0_o      = lv_cx0_q;
  assign cx1_o      = lv_cx1_q;
  assign cx2_o      = lv_cx2_q;
  assign cy0_o      = lv_cy0_q;
  assign cy1_o      = lv_cy1_q;
  assign cy2_o      = lv_cy2_q;
  assign att_o      = cur_att_q;
  assign mix_o      = lv_mix_q;
  assign flt_clr_o  = flt_clr_q;
  assign busy_o     = busy_q;

endmodule
